// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and constants for the fetch/decode instruction queue.
package fetch_decode_queue_pkg;

  typedef logic [31:0] word_t;

  // One queued instruction: its PC and the raw instruction word.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } ifq_entry_t;

  localparam word_t HALT_INSTR = 32'hFFFF_FFFF;
  localparam word_t NOP_INSTR  = 32'h0000_0000;
  localparam word_t PC_STEP    = 32'd4;

  function automatic logic is_halt(word_t instr);
    return instr == HALT_INSTR;
  endfunction

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode side signals of the instruction queue.
// master: the pipeline driving fetch and decode; slave: the queue itself.
interface fetch_decode_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import fetch_decode_queue_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  // Fetch side
  logic            ihit;
  word_t           fetch_pc;
  word_t           fetch_instr;
  logic            fetch_hold;
  // Control
  logic            flush;
  // Decode side
  logic            stall;
  logic            valid;
  word_t           out_pc;
  word_t           out_instr;
  word_t           out_npc;
  // Status
  logic [CntW-1:0] count;
  logic            halt_seen;

  modport master (
    output ihit, fetch_pc, fetch_instr, flush, stall,
    input  fetch_hold, valid, out_pc, out_instr, out_npc, count, halt_seen
  );

  modport slave (
    input  ihit, fetch_pc, fetch_instr, flush, stall,
    output fetch_hold, valid, out_pc, out_instr, out_npc, count, halt_seen
  );

endinterface

// File: rtl/fetch_decode_queue.sv
// Circular instruction queue between fetch and decode. Flush squashes all entries and the
// halt latch; once a HALT word is captured no further instructions are accepted.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                 CLK,
  input logic                 nRST,
  fetch_decode_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  // Entry storage is never reset; valid/count gate everything read from it.
  ifq_entry_t mem_q [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            halt_q, halt_d;

  logic full;
  logic not_empty;
  logic enq;
  logic deq;

  // Handshake decode and next-state for pointers, occupancy and halt latch.
  always_comb begin
    full      = (count_q == FullCnt);
    not_empty = (count_q != '0);
    // Full refuses enqueue even when a dequeue fires this cycle.
    enq       = bus.ihit & ~full & ~halt_q & ~bus.flush;
    deq       = not_empty & ~bus.stall & ~bus.flush;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    halt_d  = halt_q;

    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      halt_d  = 1'b0;
    end else begin
      if (enq) begin
        tail_d = tail_q + PtrW'(1);
      end
      if (deq) begin
        head_d = head_q + PtrW'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (enq && is_halt(bus.fetch_instr)) begin
        halt_d = 1'b1;
      end
    end
  end

  // Pointer, occupancy and halt state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      halt_q  <= halt_d;
    end
  end

  // Entry write at the tail.
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem_q[tail_q] <= '{pc: bus.fetch_pc, instr: bus.fetch_instr};
    end
  end

  ifq_entry_t head_entry;
  word_t      head_pc;

  // Outputs depend on registered state only; an empty queue presents a nop at PC 0.
  always_comb begin
    head_entry     = mem_q[head_q];
    head_pc        = not_empty ? head_entry.pc : '0;
    bus.valid      = not_empty;
    bus.out_pc     = head_pc;
    bus.out_instr  = not_empty ? head_entry.instr : NOP_INSTR;
    bus.out_npc    = head_pc + PC_STEP;
    bus.count      = count_q;
    bus.fetch_hold = full | halt_q;
    bus.halt_seen  = halt_q;
  end

  // Occupancy never exceeds capacity and always matches the pointer distance.
  a_count_bound : assert property (@(posedge CLK) disable iff (!nRST) count_q <= FullCnt);
  a_ptr_dist : assert property (@(posedge CLK) disable iff (!nRST)
    PtrW'(tail_q - head_q) == count_q[PtrW-1:0]);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed, table-driven bench for fetch_decode_queue (DEPTH = 4).
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  logic CLK = 1'b0;
  logic nRST;

  fetch_decode_queue_if #(.DEPTH(4)) bus ();

  fetch_decode_queue #(.DEPTH(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  ihit;
    word_t pc;
    word_t instr;
    logic  flush;
    logic  stall;
    logic  ev;
    word_t epc;
    word_t einstr;
    int    ecnt;
    logic  ehold;
    logic  ehalt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic word_t mk(input word_t pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic add(input logic ihit, input word_t pc, input word_t instr, input logic flush,
                     input logic stall, input logic ev, input word_t epc, input word_t einstr,
                     input int ecnt, input logic ehold, input logic ehalt);
    vec_t v;
    v.ihit = ihit;  v.pc = pc;   v.instr = instr;    v.flush = flush; v.stall = stall;
    v.ev = ev;      v.epc = epc; v.einstr = einstr;  v.ecnt = ecnt;
    v.ehold = ehold; v.ehalt = ehalt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input word_t epc,
                           input word_t einstr, input int ecnt, input logic ehold,
                           input logic ehalt);
    chk({tag, " valid"}, 32'(bus.valid), 32'(ev));
    chk({tag, " out_pc"}, bus.out_pc, epc);
    chk({tag, " out_instr"}, bus.out_instr, einstr);
    chk({tag, " out_npc"}, bus.out_npc, epc + 32'd4);
    chk({tag, " count"}, 32'(bus.count), 32'(ecnt));
    chk({tag, " fetch_hold"}, 32'(bus.fetch_hold), 32'(ehold));
    chk({tag, " halt_seen"}, 32'(bus.halt_seen), 32'(ehalt));
  endtask

  task automatic drive(input logic ihit, input word_t pc, input word_t instr,
                       input logic flush, input logic stall);
    bus.ihit = ihit; bus.fetch_pc = pc; bus.fetch_instr = instr;
    bus.flush = flush; bus.stall = stall;
  endtask

  initial begin
    // Basic: three pushes, each visible one cycle later and popped immediately.
    add(1, 32'h0, mk(32'h0), 0, 0, 1, 32'h0, mk(32'h0), 1, 0, 0);
    add(1, 32'h4, mk(32'h4), 0, 0, 1, 32'h4, mk(32'h4), 1, 0, 0);
    add(1, 32'h8, mk(32'h8), 0, 0, 1, 32'h8, mk(32'h8), 1, 0, 0);
    add(0, 32'h0, 32'h0,     0, 0, 0, 32'h0, 32'h0,     0, 0, 0);
    // Fill/hold: 5 pushes under stall, 5th refused.
    add(1, 32'h100, mk(32'h100), 0, 1, 1, 32'h100, mk(32'h100), 1, 0, 0);
    add(1, 32'h104, mk(32'h104), 0, 1, 1, 32'h100, mk(32'h100), 2, 0, 0);
    add(1, 32'h108, mk(32'h108), 0, 1, 1, 32'h100, mk(32'h100), 3, 0, 0);
    add(1, 32'h10C, mk(32'h10C), 0, 1, 1, 32'h100, mk(32'h100), 4, 1, 0);
    add(1, 32'h110, mk(32'h110), 0, 1, 1, 32'h100, mk(32'h100), 4, 1, 0);
    // Full with dequeue: push still refused (no full bypass), then drain.
    add(1, 32'h200, mk(32'h200), 0, 0, 1, 32'h104, mk(32'h104), 3, 0, 0);
    add(0, 32'h0, 32'h0,         0, 0, 1, 32'h108, mk(32'h108), 2, 0, 0);
    add(0, 32'h0, 32'h0,         0, 0, 1, 32'h10C, mk(32'h10C), 1, 0, 0);
    add(0, 32'h0, 32'h0,         0, 0, 0, 32'h0,   32'h0,       0, 0, 0);
    // Wrap: push/pop one per cycle across several pointer wraps.
    for (int k = 0; k < 10; k++) begin
      add(1, 32'(k * 4), mk(32'(k * 4)), 0, 0, 1, 32'(k * 4), mk(32'(k * 4)), 1, 0, 0);
    end
    add(0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    // Flush with 3 held entries and a concurrent push.
    add(1, 32'h30, mk(32'h30), 0, 1, 1, 32'h30, mk(32'h30), 1, 0, 0);
    add(1, 32'h34, mk(32'h34), 0, 1, 1, 32'h30, mk(32'h30), 2, 0, 0);
    add(1, 32'h38, mk(32'h38), 0, 1, 1, 32'h30, mk(32'h30), 3, 0, 0);
    add(1, 32'h40, mk(32'h40), 1, 0, 0, 32'h0,  32'h0,      0, 0, 0);
    add(0, 32'h0,  32'h0,      0, 0, 0, 32'h0,  32'h0,      0, 0, 0);
    // HALT capture, drain, rejection, and clear by flush.
    add(1, 32'h0, mk(32'h0),  0, 0, 1, 32'h0, mk(32'h0),  1, 0, 0);
    add(1, 32'h4, HALT_INSTR, 0, 0, 1, 32'h4, HALT_INSTR, 1, 1, 1);
    add(1, 32'h8, mk(32'h8),  0, 0, 0, 32'h0, 32'h0,      0, 1, 1);
    add(1, 32'hC, mk(32'hC),  0, 0, 0, 32'h0, 32'h0,      0, 1, 1);
    add(0, 32'h0, 32'h0,      1, 0, 0, 32'h0, 32'h0,      0, 0, 0);
    add(1, 32'h50, mk(32'h50), 0, 0, 1, 32'h50, mk(32'h50), 1, 0, 0);
    add(0, 32'h0, 32'h0,       0, 0, 0, 32'h0,  32'h0,      0, 0, 0);

    // Reset state.
    nRST = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);
    #12;
    check_all("reset", 0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ihit, vecs[i].pc, vecs[i].instr, vecs[i].flush, vecs[i].stall);
      @(posedge CLK);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr,
                vecs[i].ecnt, vecs[i].ehold, vecs[i].ehalt);
    end

    // Async reset between edges with 2 entries and the halt latch set.
    drive(1, 32'h60, mk(32'h60), 0, 1);
    @(posedge CLK);
    #1;
    drive(1, 32'h64, HALT_INSTR, 0, 1);
    @(posedge CLK);
    #1;
    check_all("prereset", 1, 32'h60, mk(32'h60), 2, 1, 1);
    drive(0, 32'h0, 32'h0, 0, 0);
    #3;
    nRST = 1'b0;
    #1;
    check_all("async_rst", 0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check_all("post_rst", 0, 32'h0, 32'h0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Instruction queue between the fetch stage and the decode stage of the pipelined datapath. Fetch pushes each instruction word and its PC on `ihit`. Decode pops from the head whenever it is not stalled. The queue decouples instruction-cache hit timing from decode stalls, squashes everything it holds on a taken branch or jump, and stops accepting instructions once a HALT has been captured.

## Interface
- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2.
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: reset. Asynchronous assert, active-low.
- `ihit` in 1: fetch presents a valid instruction this cycle.
- `fetch_pc` in 32: PC of the presented instruction.
- `fetch_instr` in 32: presented instruction word.
- `flush` in 1: taken branch, jump or misprediction. Squash all held entries and clear the halt latch.
- `stall` in 1: decode cannot accept the head entry this cycle.
- `fetch_hold` out 1: fetch must not advance its PC. Fetch gates its PC enable as `ihit & ~fetch_hold`.
- `valid` out 1: the head entry is present.
- `out_pc` out 32: PC of the head entry.
- `out_instr` out 32: instruction word of the head entry.
- `out_npc` out 32: `out_pc + 4`.
- `count` out $clog2(DEPTH)+1: number of occupied entries.
- `halt_seen` out 1: a HALT word (32'hFFFFFFFF) has been captured and not yet flushed.

## Operation
- Storage is a circular buffer. It has a head pointer, a tail pointer and an occupancy counter. Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
- `full` is an internal signal, equal to `count == DEPTH`.
- `fetch_hold = full | halt_seen`. It is driven from registers only.
- Enqueue fires when `ihit & ~full & ~halt_seen & ~flush`. It writes {`fetch_pc`, `fetch_instr`} at the tail and advances the tail.
- Dequeue fires when `valid & ~stall & ~flush`. It advances the head.
- Simultaneous enqueue and dequeue leave `count` unchanged and advance both pointers.
- When the queue is full, enqueue is refused even if a dequeue fires in the same cycle. There is no full-bypass path.
- When the queue is empty there is no bypass. A word enqueued in cycle N first appears at the head in cycle N+1.
- `flush` has priority over everything else. On the next edge: head = tail = 0, `count` = 0, `halt_seen` = 0. Any enqueue or dequeue in the same cycle is discarded.
- HALT capture: enqueuing 32'hFFFFFFFF sets `halt_seen` on that edge. While `halt_seen` = 1, further `ihit` is ignored. The HALT entry itself still drains to decode normally. `halt_seen` clears only on `flush` or reset.
- When `valid` = 0: `out_instr` = 32'h00000000 (nop), `out_pc` = 0, `out_npc` = 4.
- Entry contents are not cleared on flush. Only the pointers and the counter are reset.

## Timing
- Reset (asynchronous, `nRST` = 0): pointers 0, `count` 0, `valid` 0, `fetch_hold` 0, `halt_seen` 0, `out_pc` 0, `out_instr` 0, `out_npc` 4.
- Latency from enqueue to head is 1 cycle.
- Dequeue takes effect at the edge. The next entry is visible in the same cycle after that edge.
- `valid`, `out_*`, `count`, `fetch_hold` and `halt_seen` are functions of registered state only. There is no combinational path from `ihit`, `stall` or `flush` to any output.
- Reset asserted mid-operation: all state returns to reset values immediately. No partial entry survives.
- Maximum throughput is one instruction per cycle, sustained while `stall` = 0 and `ihit` = 1.

## Structure
- `cpu_types_pkg` gains `ifq_entry_t`, a packed struct holding `word_t pc` and `word_t instr`. The queue stores an array of `ifq_entry_t`.
- `cpu_types_pkg` gains a constant `HALT_INSTR` = 32'hFFFFFFFF. `word_t` is reused from the package.
- Single module with no sub-module. Pointer and count logic live in one `always_ff`. Next-state logic lives in one `always_comb`.
- `fetch_stage` connects `fetch_hold` into its PC-enable term. `decode_stage` consumes `valid` and `out_*` and drives `stall`.

## Test plan
- Basic: reset, then push PCs 0x0, 0x4, 0x8 on consecutive `ihit` with `stall` = 0. Required: `valid` rises one cycle later, and `out_pc` presents 0x0, 0x4, 0x8 in order with `out_npc` = `out_pc + 4`.
- Fill/hold: set `stall` = 1 and push 5 words with DEPTH = 4. Required: `count` saturates at 4, `fetch_hold` = 1, and the 5th word is not stored. Release `stall`: exactly 4 words drain in order.
- Wrap: run 10 push/pop pairs at one per cycle. Required: PCs 0x0..0x24 appear in order across the pointer wrap and `count` stays at 1.
- Flush: with 3 entries held, assert `flush` together with `ihit` (PC 0x40). Required: next cycle `count` = 0, `valid` = 0, `out_instr` = 0, and 0x40 is not stored.
- HALT: push 0x0, then HALT at 0x4, then 0x8. Required: `halt_seen` = 1 after the HALT edge, 0x8 is rejected, and the HALT drains to decode. A later `flush` clears `halt_seen`.
- Async reset mid-fill: drop `nRST` between edges while `count` = 2. Required: all outputs reach their reset values without waiting for a clock edge.
